instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of instruction-memory words the block writes; it is a power of two, at least 2.
REQ-002 SHALL have localparam AW = log2(DEPTH), meaning the address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins a new program load.
REQ-006 SHALL have port in_valid, input, 1 bit: the instruction fields are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the fields this cycle.
REQ-008 SHALL have port op_sel, input, 3 bits, with this mapping: 0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 illegal.
REQ-009 SHALL have port ra, input, 5 bits: Rd for R-format, Rt for D and CB formats.
REQ-010 SHALL have port rb, input, 5 bits: Rn.
REQ-011 SHALL have port rc, input, 5 bits: Rm.
REQ-012 SHALL have port imm, input, 19 bits: the D-format DT_address is imm[8:0]; the CB-format address is imm[18:0].
REQ-013 SHALL have port imem_we, output, 1 bit: instruction-memory write enable.
REQ-014 SHALL have port imem_addr, output, AW bits: word address of the write.
REQ-015 SHALL have port imem_wdata, output, 32 bits: the encoded instruction.
REQ-016 SHALL have port word_count, output, AW+1 bits: legal words written since start.
REQ-017 SHALL have port full, output, 1 bit: DEPTH words have been written.
REQ-018 SHALL have port err, output, 1 bit: sticky flag set when an illegal op_sel is accepted.

Function
REQ-019 SHALL implement an FSM with states IDLE, RUN and FULL; reset enters IDLE.
REQ-020 SHALL drive in_ready = (state==RUN) && !start, combinationally.
REQ-021 SHALL treat an accept as the event in_valid && in_ready at a rising edge.
REQ-022 SHALL, on start in any state, clear the address counter, word_count and err, and enter RUN; an input presented in the same cycle is not accepted.
REQ-023 SHALL, on a legal accept at cycle t, drive imem_we=1 in cycle t+1 with imem_addr = the counter value at t and imem_wdata = the encoding; otherwise imem_we=0.
REQ-024 SHALL register imem_addr and imem_wdata and hold them when imem_we=0.
REQ-025 SHALL encode R-format ops as {opcode[10:0], rc, 6'b0, rb, ra}, with opcodes ADD 10001011000, SUB 11001011000, AND 10001010000 and ORR 10101010000.
REQ-026 SHALL encode D-format ops as {opcode, imm[8:0], 2'b00, rb, ra}, with opcodes LDUR 11111000010 and STUR 11111000000.
REQ-027 SHALL encode CBZ as {8'b10110100, imm[18:0], ra}.
REQ-028 SHALL ignore every field that the selected format does not use.
REQ-029 SHALL increment the address counter and word_count on each legal accept.
REQ-030 SHALL, on a legal accept while the counter is DEPTH-1, enter FULL, set full=1 and wrap the counter to 0; word_count becomes DEPTH.
REQ-031 SHALL, on an illegal accept (op_sel=7), set err=1 and leave the counter unchanged with no write; the FSM stays in RUN.
REQ-032 SHALL remain in FULL, with in_ready=0, until start or reset.
REQ-033 SHALL, while in IDLE or FULL, ignore in_valid.
REQ-034 SHALL make full=1 iff state==FULL.

Reset
REQ-035 SHALL, when reset is low, asynchronously force: state IDLE, counter 0, word_count 0, full 0, err 0, imem_we 0, imem_addr 0, imem_wdata 0.
REQ-036 SHALL, when reset is asserted in mid-operation, drop any pending write: imem_we is 0 from the reset assertion onward.
REQ-037 SHALL resume only through start after reset is released.

Verification
REQ-038 Reset then start, then ADD with ra=1, rb=2, rc=3 -> one cycle later imem_we=1, imem_addr=0, imem_wdata=0x8B030041; word_count=1.
REQ-039 LDUR with ra=5, rb=6, imm=8, then CBZ with ra=7, imm=4, on back-to-back cycles -> writes 0xF84080C5 at address 0 and 0xB4000087 at address 1 on consecutive cycles.
REQ-040 op_sel=7, then SUB with ra=0, rb=0, rc=0 -> err=1, no write for op 7, SUB 0xCB000000 written at address 0; err stays 1 until the next start.
REQ-041 DEPTH=4, five accepts -> four writes at addresses 0 to 3; full=1 and in_ready=0 after the fourth; the fifth is not accepted; word_count=4.
REQ-042 start asserted with in_valid=1 in the same cycle -> no accept, counter 0; the next-cycle accept writes to address 0.
REQ-043 reset pulled low the cycle after an accept -> imem_we=0 immediately, all outputs 0, in_ready=0 until start.

Source files
------------

// File: rtl/instr_encoder.sv
// Program loader: encodes LEGv8-style instruction fields (LDUR/STUR/CBZ/ADD/SUB/AND/ORR)
// into 32-bit words and writes them sequentially into an instruction memory.
module instr_encoder #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op_sel,
    input  logic [4:0]               ra,
    input  logic [4:0]               rb,
    input  logic [4:0]               rc,
    input  logic [18:0]              imm,
    output logic                     imem_we,
    output logic [$clog2(DEPTH)-1:0] imem_addr,
    output logic [31:0]              imem_wdata,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     full,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);

    localparam logic [2:0] OP_LDUR = 3'd0;
    localparam logic [2:0] OP_STUR = 3'd1;
    localparam logic [2:0] OP_CBZ  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_ORR  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   cnt_r;
    logic [AW:0]     wc_r;
    logic            full_r;
    logic            err_r;
    logic            we_r;
    logic [AW-1:0]   addr_r;
    logic [31:0]     wdata_r;

    logic            rdy_s;
    logic            acc_s;
    logic            legal_s;
    logic [31:0]     enc_s;

    // Builds the machine word; fields unused by the selected format never reach the result.
    function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] f_ra,
                                           input logic [4:0] f_rb, input logic [4:0] f_rc,
                                           input logic [18:0] f_imm);
        logic [31:0] word;
        case (op)
            OP_LDUR: word = {11'b11111000010, f_imm[8:0], 2'b00, f_rb, f_ra};
            OP_STUR: word = {11'b11111000000, f_imm[8:0], 2'b00, f_rb, f_ra};
            OP_CBZ:  word = {8'b10110100, f_imm, f_ra};
            OP_ADD:  word = {11'b10001011000, f_rc, 6'b000000, f_rb, f_ra};
            OP_SUB:  word = {11'b11001011000, f_rc, 6'b000000, f_rb, f_ra};
            OP_AND:  word = {11'b10001010000, f_rc, 6'b000000, f_rb, f_ra};
            OP_ORR:  word = {11'b10101010000, f_rc, 6'b000000, f_rb, f_ra};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // Handshake decode and encoding of the presented fields.
    always_comb begin
        rdy_s   = 1'b0;
        acc_s   = 1'b0;
        legal_s = 1'b0;
        enc_s   = 32'h0000_0000;
        if ((state_r == ST_RUN) && !start) begin
            rdy_s = 1'b1;
        end else begin
            rdy_s = 1'b0;
        end
        acc_s   = rdy_s & in_valid;
        legal_s = (op_sel != OP_ILL);
        enc_s   = encode(op_sel, ra, rb, rc, imm);
    end

    assign in_ready = rdy_s;

    // Load sequencer: state, address counter, status flags and the registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            wc_r    <= '0;
            full_r  <= 1'b0;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
        end else if (start) begin
            // A start cycle never accepts, so no write follows it.
            state_r <= ST_RUN;
            cnt_r   <= '0;
            wc_r    <= '0;
            full_r  <= 1'b0;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (acc_s && legal_s) begin
                        we_r    <= 1'b1;
                        addr_r  <= cnt_r;
                        wdata_r <= enc_s;
                        cnt_r   <= cnt_r + AW'(1);
                        wc_r    <= wc_r + (AW + 1)'(1);
                        if (cnt_r == CNT_MAX) begin
                            state_r <= ST_FULL;
                            full_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            full_r  <= 1'b0;
                        end
                    end else if (acc_s) begin
                        we_r  <= 1'b0;
                        err_r <= 1'b1;
                    end else begin
                        we_r <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    we_r <= 1'b0;
                end
                ST_FULL: begin
                    we_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    full_r  <= 1'b0;
                    we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign word_count = wc_r;
    assign full       = full_r;
    assign err        = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder with a word-level reference model.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op_sel = 3'd0;
    logic [4:0]    ra = 5'd0;
    logic [4:0]    rb = 5'd0;
    logic [4:0]    rc = 5'd0;
    logic [18:0]   imm = 19'd0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic          err;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          m_run = 1'b0;
    bit          m_full = 1'b0;
    bit          m_err = 1'b0;
    int          m_addr = 0;
    int          m_count = 0;
    int          last_addr = 0;
    logic [31:0] last_data = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word from opcode values and field weights.
    function automatic logic [31:0] ref_enc(input int op, input int a, input int b, input int c,
                                            input int im);
        longint r;
        case (op)
            0: r = 64'd1986 * 64'd2097152 + longint'(im % 512) * 64'd4096 + longint'(b) * 64'd32 + longint'(a);
            1: r = 64'd1984 * 64'd2097152 + longint'(im % 512) * 64'd4096 + longint'(b) * 64'd32 + longint'(a);
            2: r = 64'd180 * 64'd16777216 + longint'(im) * 64'd32 + longint'(a);
            3: r = 64'd1112 * 64'd2097152 + longint'(c) * 64'd65536 + longint'(b) * 64'd32 + longint'(a);
            4: r = 64'd1624 * 64'd2097152 + longint'(c) * 64'd65536 + longint'(b) * 64'd32 + longint'(a);
            5: r = 64'd1104 * 64'd2097152 + longint'(c) * 64'd65536 + longint'(b) * 64'd32 + longint'(a);
            6: r = 64'd1360 * 64'd2097152 + longint'(c) * 64'd65536 + longint'(b) * 64'd32 + longint'(a);
            default: r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    task automatic model_edge();
        wr_t w;
        if (!reset) return;
        if (start) begin
            m_run = 1'b1; m_full = 1'b0; m_err = 1'b0; m_addr = 0; m_count = 0;
        end else if (m_run && in_valid) begin
            if (op_sel == 3'd7) begin
                m_err = 1'b1;
            end else begin
                w.addr = m_addr;
                w.data = ref_enc(int'(op_sel), int'(ra), int'(rb), int'(rc), int'(imm));
                exp_q.push_back(w);
                m_addr = (m_addr + 1) % DEPTH;
                m_count++;
                if (m_count == DEPTH) begin
                    m_run = 1'b0; m_full = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input bit s, input bit v, input int op, input int a, input int b,
                         input int c, input int im);
        start = s; in_valid = v; op_sel = 3'(op); ra = 5'(a); rb = 5'(b); rc = 5'(c); imm = 19'(im);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run = 1'b0; m_full = 1'b0; m_err = 1'b0; m_addr = 0; m_count = 0;
        last_addr = 0; last_data = 32'h0;
    endtask

    // Monitor: compares status every cycle and retires the write due in this cycle.
    always @(negedge clk) begin
        wr_t w;
        check("in_ready", 64'(in_ready), 64'(m_run && !start));
        check("word_count", 64'(word_count), 64'(m_count));
        check("full", 64'(full), 64'(m_full));
        check("err", 64'(err), 64'(m_err));
        check("imem_we", 64'(imem_we), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            last_addr = w.addr;
            last_data = w.data;
        end
        check("imem_addr", 64'(imem_addr), 64'(last_addr));
        check("imem_wdata", 64'(imem_wdata), 64'(last_data));
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 1, 3, 1, 2, 3, 0);                 // idle: valid ignored
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 1, 2, 3, 0);                 // ADD x1,x2,x3
        check("add_word", 64'(imem_wdata), 64'h8B030041);
        check("add_addr", 64'(imem_addr), 64'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 5, 6, 9, 8);                 // LDUR, rc ignored
        check("ldur_word", 64'(imem_wdata), 64'hF84080C5);
        drive(0, 1, 2, 7, 30, 31, 4);               // CBZ, rb/rc ignored
        check("cbz_word", 64'(imem_wdata), 64'hB4000087);
        check("cbz_addr", 64'(imem_addr), 64'd1);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 7, 3, 3, 3, 3);                 // illegal op
        check("ill_nowrite", 64'(imem_we), 64'd0);
        check("ill_err", 64'(err), 64'd1);
        drive(0, 1, 4, 0, 0, 0, 0);                 // SUB x0,x0,x0
        check("sub_word", 64'(imem_wdata), 64'hCB000000);
        check("sub_addr", 64'(imem_addr), 64'd0);
        drive(1, 1, 3, 4, 4, 4, 0);                 // start with valid: no accept
        check("start_noacc", 64'(imem_we), 64'd0);
        drive(0, 1, 6, 9, 8, 7, 0);
        check("after_start_addr", 64'(imem_addr), 64'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, i % 7, i, i + 1, i + 2, i * 100);
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(word_count), 64'(DEPTH));
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5, 1, 2, 3, 0);                 // accept, then reset next cycle
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        drive(0, 1, 3, 1, 1, 1, 0);
        reset = 1'b1;
        drive(0, 1, 3, 1, 1, 1, 0);                 // released but no start: ignored
        drive(0, 1, 3, 1, 1, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 524287)));
        end
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
